mc_control_fsm: RTL
===================

// Module: mc_control_fsm
// PURPOSE
//  Moore control FSM that sequences the MIPS datapath as a multicycle machine. It shares one
//  unified memory port between instruction fetch and data access, and stalls on a memory ready
//  handshake. It decodes opcode/funct and drives every datapath enable, mux select and the
//  6-bit ALU control. It sits between the instruction register and the datapath/memory.
// PARAMETERS
//  CNT_W   32  width of perf counters (used only with MC_PERF_CNT_EN)
// PORTS
//  clk         in   1  rising-edge clock
//  reset       in   1  async, active-low; 0 = in reset
//  opcode      in   6  instr[31:26] from instruction register
//  funct       in   6  instr[5:0]
//  zero        in   1  ALU zero flag
//  mem_ready   in   1  memory has completed the current access this cycle
//  mem_req     out  1  memory access request (FETCH, MEMRD, MEMWR)
//  memwrite    out  1  write strobe, valid with mem_req in MEMWR
//  iord        out  1  0 = address from pc, 1 = address from aluout register
//  irwrite     out  1  load instruction register
//  pcen        out  1  pc register enable
//  pcsrc       out  2  00 alu result, 01 aluout reg (branch), 10 jump target
//  regwrite    out  1  register file write enable
//  regdst      out  1  0 = rt, 1 = rd
//  memtoreg    out  1  0 = aluout, 1 = data reg
//  alusrca     out  1  0 = pc, 1 = rs
//  alusrcb     out  2  00 rt, 01 const 4, 10 signimm, 11 signimm<<2
//  extop       out  1  0 = sign-extend, 1 = zero-extend immediate
//  alucontrol  out  6  ALU op (funct-coded)
//  instr_done  out  1  one-cycle pulse in the last state of each instruction
//  illegal     out  1  one-cycle pulse in DECODE on an unknown opcode
// BEHAVIOUR
//  - States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, IEX, IWB, BEQ, JMP.
//  - Reset: state=FETCH. All enables (pcen, irwrite, regwrite, memwrite, mem_req) are forced 0
//    while reset=0; selects are 0. A reset mid-instruction abandons it and does no partial write.
//  - FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, ALU_ADD, pcsrc=00.
//    irwrite and pcen assert only when mem_ready=1. Hold in FETCH while mem_ready=0.
//  - DECODE: alusrca=0, alusrcb=11, ALU_ADD (computes branch target).
//    lw/sw->MEMADR, R->REX, addi/andi/ori->IEX, beq->BEQ, j->JMP.
//    Unknown opcode -> FETCH with illegal=1 and instr_done=1.
//  - MEMADR: alusrca=1, alusrcb=10, ALU_ADD. lw->MEMRD, sw->MEMWR.
//  - MEMRD: mem_req=1, iord=1. Hold until mem_ready, then MEMWB.
//  - MEMWR: mem_req=1, iord=1, memwrite=1. Hold until mem_ready, then FETCH with instr_done.
//  - MEMWB: regwrite=1, regdst=0, memtoreg=1.
//  - REX: alusrca=1, alusrcb=00, alucontrol=funct.
//  - RWB: regwrite=1, regdst=1, memtoreg=0.
//  - IEX: alusrca=1, alusrcb=10. addi ALU_ADD extop=0; andi ALU_AND extop=1; ori ALU_OR extop=1.
//  - IWB: regwrite=1, regdst=0.
//  - BEQ: alusrca=1, alusrcb=00, ALU_SUB, pcsrc=01, pcen=zero.
//  - JMP: pcsrc=10, pcen=1.
//  - Last states (MEMWB, MEMWR on ready, RWB, IWB, BEQ, JMP) pulse instr_done and go to FETCH.
//  - Latency at zero wait states: lw 5 cycles; sw, R, I 4; beq, j 3. Each cycle that
//    mem_ready=0 in a memory state adds 1 cycle.
//  - mem_ready outside memory states is ignored. memwrite is never asserted outside MEMWR.
//  - ALU codes: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010, SLL 000000.
// CONFIGURATION
//  MC_PERF_CNT_EN defined:
//   - adds outputs cycle_cnt[CNT_W-1:0] and instr_cnt[CNT_W-1:0];
//   - both clear on reset and wrap at 2^CNT_W;
//   - cycle_cnt increments every cycle; instr_cnt increments on instr_done (illegal included).
//  MC_PERF_CNT_EN undefined: these ports and counters do not exist; all other behaviour is
//  identical.
// STRUCTURE
//  - Package mips_ctrl_pkg: state enum, opcode constants (R 000000, LW 100011, SW 101011,
//    BEQ 000100, ADDI 001000, ANDI 001100, ORI 001101, J 000010), ALU code constants,
//    alusrcb/pcsrc encodings.
//  - Sub-module mc_aludec: combinational (state, opcode, funct) -> alucontrol, extop.
//  - FSM state register and output decode stay in mc_control_fsm.
// TESTING
//  1. Release reset with opcode=R, funct=100000, mem_ready=1 ->
//     FETCH(pcen,irwrite), DECODE, REX(alucontrol=100000), RWB(regwrite,regdst=1);
//     instr_done at cycle 4.
//  2. lw with mem_ready low 3 cycles in MEMRD -> mem_req=1, iord=1 held 4 cycles,
//     regwrite=0 until MEMWB; total 8 cycles.
//  3. beq with zero=1 -> pcen=1, pcsrc=01 in BEQ. Repeat with zero=0 -> pcen=0; both take
//     3 cycles.
//  4. ori -> IEX alucontrol=100101, extop=1; IWB regwrite=1, regdst=0.
//     Opcode 111111 -> illegal pulse in DECODE, back to FETCH.
//  5. Assert reset=0 during MEMWR with mem_ready=0 -> memwrite and mem_req drop immediately,
//     state=FETCH after release, no regwrite.
//  6. With MC_PERF_CNT_EN, run 10 R-type instructions at zero wait -> instr_cnt=10,
//     cycle_cnt=40.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: state enum, opcode
// and ALU codes, mux-select encodings and the per-state control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_REX,
        S_RWB,
        S_IEX,
        S_IWB,
        S_BEQ,
        S_JMP
    } state_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    // ALU operation codes (funct-coded)
    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;
    localparam logic [5:0] ALU_AND = 6'b100100;
    localparam logic [5:0] ALU_OR  = 6'b100101;
    localparam logic [5:0] ALU_SLT = 6'b101010;
    localparam logic [5:0] ALU_SLL = 6'b000000;

    // ALU B-operand select
    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Control word that depends only on the state. Handshake-dependent strobes
    // (fetch/beq/jmp/done_on_ready/decode) are qualified with live inputs later.
    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       fetch;
        logic       decode;
        logic       beq;
        logic       jmp;
        logic [1:0] pcsrc;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       done_last;
        logic       done_on_ready;
    } ctrl_t;

    function automatic logic opcode_known(input logic [5:0] op);
        return (op == OP_R)    || (op == OP_LW)   || (op == OP_SW)  ||
               (op == OP_BEQ)  || (op == OP_ADDI) || (op == OP_ANDI) ||
               (op == OP_ORI)  || (op == OP_J);
    endfunction

    function automatic ctrl_t ctrl_decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req = 1'b1;
                c.fetch   = 1'b1;
                c.alusrcb = SRCB_FOUR;
                c.pcsrc   = PCSRC_ALU;
            end
            S_DECODE: begin
                c.decode  = 1'b1;
                c.alusrcb = SRCB_IMMSH;
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.regwrite  = 1'b1;
                c.memtoreg  = 1'b1;
                c.done_last = 1'b1;
            end
            S_MEMWR: begin
                c.mem_req       = 1'b1;
                c.iord          = 1'b1;
                c.memwrite      = 1'b1;
                c.done_on_ready = 1'b1;
            end
            S_REX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_RT;
            end
            S_RWB: begin
                c.regwrite  = 1'b1;
                c.regdst    = 1'b1;
                c.done_last = 1'b1;
            end
            S_IEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
            end
            S_IWB: begin
                c.regwrite  = 1'b1;
                c.done_last = 1'b1;
            end
            S_BEQ: begin
                c.alusrca   = 1'b1;
                c.alusrcb   = SRCB_RT;
                c.pcsrc     = PCSRC_ALUOUT;
                c.beq       = 1'b1;
                c.done_last = 1'b1;
            end
            S_JMP: begin
                c.pcsrc     = PCSRC_JUMP;
                c.jmp       = 1'b1;
                c.done_last = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: selects the 6-bit ALU operation and immediate extension mode
// from the current FSM state and the instruction fields.
module mc_aludec
    import mips_ctrl_pkg::*;
(
    input  state_t      i_state,
    input  logic [5:0]  i_opcode,
    input  logic [5:0]  i_funct,
    output logic [5:0]  o_alucontrol,
    output logic        o_extop
);

    // Address/PC arithmetic defaults to ADD; R-type passes funct straight through.
    always_comb begin
        o_alucontrol = ALU_ADD;
        o_extop      = 1'b0;
        case (i_state)
            S_REX: o_alucontrol = i_funct;
            S_IEX: begin
                case (i_opcode)
                    OP_ANDI: begin
                        o_alucontrol = ALU_AND;
                        o_extop      = 1'b1;
                    end
                    OP_ORI: begin
                        o_alucontrol = ALU_OR;
                        o_extop      = 1'b1;
                    end
                    default: o_alucontrol = ALU_ADD;
                endcase
            end
            S_BEQ:   o_alucontrol = ALU_SUB;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM with a shared memory port and ready handshake.
// Optional performance counters (cycle_cnt, instr_cnt) are built only when
// MC_PERF_CNT_EN is defined.
module mc_control_fsm
    import mips_ctrl_pkg::*;
`ifdef MC_PERF_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        memwrite,
    output logic        iord,
    output logic        irwrite,
    output logic        pcen,
    output logic [1:0]  pcsrc,
    output logic        regwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic        extop,
    output logic [5:0]  alucontrol,
    output logic        instr_done,
    output logic        illegal
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    state_t      r_state;
    state_t      w_state_next;
    ctrl_t       r_ctrl;
    logic        w_illegal;
    logic [5:0]  w_alucontrol;
    logic        w_extop;

    // Next-state logic: memory states hold until mem_ready, decode dispatches on opcode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH:  if (mem_ready) w_state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:             w_state_next = S_MEMADR;
                    OP_R:                     w_state_next = S_REX;
                    OP_ADDI, OP_ANDI, OP_ORI: w_state_next = S_IEX;
                    OP_BEQ:                   w_state_next = S_BEQ;
                    OP_J:                     w_state_next = S_JMP;
                    default:                  w_state_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) w_state_next = S_MEMWB;
            S_MEMWR:  if (mem_ready) w_state_next = S_FETCH;
            S_REX:    w_state_next = S_RWB;
            S_IEX:    w_state_next = S_IWB;
            S_MEMWB, S_RWB, S_IWB, S_BEQ, S_JMP: w_state_next = S_FETCH;
            default:  w_state_next = S_FETCH;
        endcase
    end

    // State register with the control word registered alongside it, so the
    // state-only outputs come straight from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= ctrl_decode(S_FETCH);
        end else begin
            r_state <= w_state_next;
            r_ctrl  <= ctrl_decode(w_state_next);
        end
    end

    mc_aludec u_aludec (
        .i_state      (r_state),
        .i_opcode     (opcode),
        .i_funct      (funct),
        .o_alucontrol (w_alucontrol),
        .o_extop      (w_extop)
    );

    // Output stage: qualify strobes with the handshake/zero flag and force
    // everything low while reset is held so no partial access leaks out.
    always_comb begin
        w_illegal  = r_ctrl.decode & ~opcode_known(opcode);
        mem_req    = reset & r_ctrl.mem_req;
        memwrite   = reset & r_ctrl.memwrite;
        iord       = reset & r_ctrl.iord;
        irwrite    = reset & r_ctrl.fetch & mem_ready;
        pcen       = reset & ((r_ctrl.fetch & mem_ready) | (r_ctrl.beq & zero) | r_ctrl.jmp);
        pcsrc      = reset ? r_ctrl.pcsrc : 2'b00;
        regwrite   = reset & r_ctrl.regwrite;
        regdst     = reset & r_ctrl.regdst;
        memtoreg   = reset & r_ctrl.memtoreg;
        alusrca    = reset & r_ctrl.alusrca;
        alusrcb    = reset ? r_ctrl.alusrcb : 2'b00;
        extop      = reset & w_extop;
        alucontrol = reset ? w_alucontrol : 6'b000000;
        instr_done = reset & (r_ctrl.done_last | (r_ctrl.done_on_ready & mem_ready) | w_illegal);
        illegal    = reset & w_illegal;
    end

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    // Free-running cycle and retired-instruction counters, wrapping naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (instr_done) begin
                r_instr_cnt <= r_instr_cnt + 1'b1;
            end
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`endif

endmodule
